// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM states, RAM geometry
// and the sample-to-display-byte conversion used by any waveform source.
package wave_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } wave_state_t;

  localparam int WAVE_ADDR_W = 9;
  localparam int WAVE_IDX_W  = 8;
  localparam int WAVE_DATA_W = 8;

  // Signed top byte to offset-binary: flip the sign bit so 0 sits mid-scale.
  function automatic logic [WAVE_DATA_W-1:0] offset_binary(
    input logic [WAVE_DATA_W-1:0] msbs
  );
    return {~msbs[WAVE_DATA_W-1], msbs[WAVE_DATA_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_qualifier.sv
// Decimates the codec sample pulses, tracks the sign of the last accepted
// sample and flags rising zero crossings.
module sample_qualifier
  import wave_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DECIM    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_sample_ready,
  input  logic [SAMPLE_W-1:0]    new_sample_in,
  output logic                   accepted,
  output logic                   crossing,
  output logic [WAVE_DATA_W-1:0] sample_conv
);

  localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);

  logic [7:0] decim_cnt_reg;
  logic       prev_neg_reg;
  logic       sample_neg;

  assign sample_neg = new_sample_in[SAMPLE_W-1];

  // Left combinational so the top can register the RAM write on the very
  // edge that follows the accepted pulse.
  assign accepted    = new_sample_ready && (decim_cnt_reg == 8'd0);
  assign crossing    = accepted && !sample_neg && prev_neg_reg;
  assign sample_conv = offset_binary(new_sample_in[SAMPLE_W-1 -: WAVE_DATA_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      decim_cnt_reg <= 8'd0;
      prev_neg_reg  <= 1'b0;
    end else begin
      if (new_sample_ready) begin
        decim_cnt_reg <= (decim_cnt_reg == DECIM_LAST) ? 8'd0 : decim_cnt_reg + 8'd1;
      end
      if (accepted) begin
        prev_neg_reg <= sample_neg;
      end
    end
  end

endmodule

// File: rtl/wave_capture_ctrl.sv
// Captures 256 decimated samples after a rising zero crossing (or timeout)
// into the hidden half of the waveform RAM, then swaps halves during blanking.
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int DECIM        = 1,
  parameter int TRIG_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_sample_ready,
  input  logic [SAMPLE_W-1:0]    new_sample_in,
  input  logic                   wave_display_idle,
  output logic                   write_enable,
  output logic [WAVE_ADDR_W-1:0] write_address,
  output logic [WAVE_DATA_W-1:0] write_sample,
  output logic                   read_index,
  output logic                   flip,
  output logic                   free_run
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TRIG_TIMEOUT - 1);
  localparam logic [WAVE_IDX_W-1:0] IDX_LAST = '1;

  logic                   accepted;
  logic                   crossing;
  logic [WAVE_DATA_W-1:0] sample_conv;

  wave_state_t            state_reg, state_next;
  logic [WAVE_IDX_W-1:0]  index_reg, index_next;
  logic [15:0]            timeout_reg, timeout_next;
  logic                   read_index_reg, read_index_next;
  logic                   flip_reg, flip_next;
  logic                   free_run_reg, free_run_next;
  logic                   pending_reg, pending_next;
  logic                   we_reg, we_next;
  logic [WAVE_ADDR_W-1:0] addr_reg, addr_next;
  logic [WAVE_DATA_W-1:0] sample_reg, sample_next;

  sample_qualifier #(
    .SAMPLE_W (SAMPLE_W),
    .DECIM    (DECIM)
  ) u_qual (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .accepted         (accepted),
    .crossing         (crossing),
    .sample_conv      (sample_conv)
  );

  always_comb begin
    state_next      = state_reg;
    index_next      = index_reg;
    timeout_next    = timeout_reg;
    read_index_next = read_index_reg;
    flip_next       = 1'b0;
    free_run_next   = free_run_reg;
    pending_next    = pending_reg;
    we_next         = 1'b0;
    addr_next       = addr_reg;
    sample_next     = sample_reg;

    case (state_reg)
      ARMED: begin
        if (accepted) begin
          if (crossing || (timeout_reg == TIMEOUT_LAST)) begin
            we_next      = 1'b1;
            addr_next    = {~read_index_reg, {WAVE_IDX_W{1'b0}}};
            sample_next  = sample_conv;
            index_next   = 8'd1;
            // A real crossing wins when it coincides with the timeout.
            pending_next = !crossing;
            state_next   = ACTIVE;
          end else begin
            timeout_next = timeout_reg + 16'd1;
          end
        end
      end
      ACTIVE: begin
        if (accepted) begin
          we_next     = 1'b1;
          addr_next   = {~read_index_reg, index_reg};
          sample_next = sample_conv;
          index_next  = index_reg + 8'd1;
          if (index_reg == IDX_LAST) begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        // Accepted samples here only move prev_neg, so a crossing on the
        // swap cycle cannot trigger the next capture.
        if (wave_display_idle) begin
          read_index_next = ~read_index_reg;
          flip_next       = 1'b1;
          free_run_next   = pending_reg;
          timeout_next    = 16'd0;
          state_next      = ARMED;
        end
      end
      default: begin
        state_next = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ARMED;
      index_reg      <= '0;
      timeout_reg    <= '0;
      read_index_reg <= 1'b0;
      flip_reg       <= 1'b0;
      free_run_reg   <= 1'b0;
      pending_reg    <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      sample_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      index_reg      <= index_next;
      timeout_reg    <= timeout_next;
      read_index_reg <= read_index_next;
      flip_reg       <= flip_next;
      free_run_reg   <= free_run_next;
      pending_reg    <= pending_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      sample_reg     <= sample_next;
    end
  end

  assign write_enable  = we_reg;
  assign write_address = addr_reg;
  assign write_sample  = sample_reg;
  assign read_index    = read_index_reg;
  assign flip          = flip_reg;
  assign free_run      = free_run_reg;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: three instances (default, DECIM=4,
// TRIG_TIMEOUT=8) share stimulus; each step checks the relevant instance.
module tb_wave_capture_ctrl;
  import wave_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;

  logic       we_w [3];
  logic [8:0] addr_w [3];
  logic [7:0] smp_w [3];
  logic       ri_w [3];
  logic       flip_w [3];
  logic       fr_w [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wave_capture_ctrl #(.SAMPLE_W(16), .DECIM(1), .TRIG_TIMEOUT(1024)) dut_a (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(we_w[0]), .write_address(addr_w[0]), .write_sample(smp_w[0]),
    .read_index(ri_w[0]), .flip(flip_w[0]), .free_run(fr_w[0]));

  wave_capture_ctrl #(.SAMPLE_W(16), .DECIM(4), .TRIG_TIMEOUT(1024)) dut_d (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(we_w[1]), .write_address(addr_w[1]), .write_sample(smp_w[1]),
    .read_index(ri_w[1]), .flip(flip_w[1]), .free_run(fr_w[1]));

  wave_capture_ctrl #(.SAMPLE_W(16), .DECIM(1), .TRIG_TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset), .new_sample_ready(new_sample_ready),
    .new_sample_in(new_sample_in), .wave_display_idle(wave_display_idle),
    .write_enable(we_w[2]), .write_address(addr_w[2]), .write_sample(smp_w[2]),
    .read_index(ri_w[2]), .flip(flip_w[2]), .free_run(fr_w[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    new_sample_ready = 1'b0;
    wave_display_idle = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated pulse; returns at the negedge where its write (if any) shows.
  task automatic send(input logic [15:0] v);
    @(negedge clk);
    new_sample_ready = 1'b1;
    new_sample_in = v;
    @(negedge clk);
    new_sample_ready = 1'b0;
  endtask

  task automatic chk_write(input int d, input logic [8:0] addr, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    check("fill_we", 32'(we_w[d]), 32'd1);
    check("fill_addr", 32'(addr_w[d]), 32'(addr));
    check("fill_sample", 32'(smp_w[d]), 32'(kb ^ 8'h80));
  endtask

  // n back-to-back pulses carrying k<<8 (k=1..n), each checked as a write.
  task automatic fill(input int d, input int n, input logic [8:0] first_addr);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k > 1) chk_write(d, first_addr + 9'(k - 2), k - 1);
      new_sample_ready = 1'b1;
      new_sample_in = 16'(k << 8);
    end
    @(negedge clk);
    new_sample_ready = 1'b0;
    chk_write(d, first_addr + 9'(n - 1), n);
  endtask

  task automatic do_flip(input int d, input logic exp_ri);
    @(negedge clk);
    wave_display_idle = 1'b1;
    @(negedge clk);
    wave_display_idle = 1'b0;
    check("flip_pulse", 32'(flip_w[d]), 32'd1);
    check("flip_read_index", 32'(ri_w[d]), 32'(exp_ri));
    @(negedge clk);
    check("flip_one_cycle", 32'(flip_w[d]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1: reset state and first crossing trigger
    do_reset();
    check("rst_we", 32'(we_w[0]), 32'd0);
    check("rst_addr", 32'(addr_w[0]), 32'd0);
    check("rst_sample", 32'(smp_w[0]), 32'd0);
    check("rst_read_index", 32'(ri_w[0]), 32'd0);
    check("rst_flip", 32'(flip_w[0]), 32'd0);
    check("rst_free_run", 32'(fr_w[0]), 32'd0);
    check("rst_state", 32'(dut_a.state_reg), 32'(ARMED));
    send(16'hFFFB);
    check("t1_neg_no_write", 32'(we_w[0]), 32'd0);
    send(16'h0003);
    check("t1_we", 32'(we_w[0]), 32'd1);
    check("t1_addr", 32'(addr_w[0]), 32'h100);
    check("t1_sample", 32'(smp_w[0]), 32'h80);
    check("t1_state", 32'(dut_a.state_reg), 32'(ACTIVE));
    @(negedge clk);
    check("t1_we_one_cycle", 32'(we_w[0]), 32'd0);
    check("t1_addr_hold", 32'(addr_w[0]), 32'h100);

    // Test 2: full capture, 257th ignored, swap, next capture in low half
    fill(0, 255, 9'h101);
    send(16'd100);
    check("t2_257_no_write", 32'(we_w[0]), 32'd0);
    check("t2_addr_hold", 32'(addr_w[0]), 32'h1FF);
    check("t2_state_wait", 32'(dut_a.state_reg), 32'(WAIT));
    check("t2_ri_before_idle", 32'(ri_w[0]), 32'd0);
    do_flip(0, 1'b1);
    check("t2_state_armed", 32'(dut_a.state_reg), 32'(ARMED));
    check("t2_free_run", 32'(fr_w[0]), 32'd0);
    send(16'hFFFF);
    check("t2_neg_no_write", 32'(we_w[0]), 32'd0);
    send(16'h0001);
    check("t2_we", 32'(we_w[0]), 32'd1);
    check("t2_addr_low", 32'(addr_w[0]), 32'h000);
    check("t2_sample", 32'(smp_w[0]), 32'h80);
    send(16'h7F00);
    check("t2_addr_1", 32'(addr_w[0]), 32'h001);
    check("t2_sample_max", 32'(smp_w[0]), 32'hFF);

    // Test 5: reset mid-capture at index 100
    fill(0, 98, 9'h002);
    check("t5_index", 32'(dut_a.index_reg), 32'd100);
    do_reset();
    check("t5_we", 32'(we_w[0]), 32'd0);
    check("t5_read_index", 32'(ri_w[0]), 32'd0);
    check("t5_state", 32'(dut_a.state_reg), 32'(ARMED));
    send(16'hFFFF);
    send(16'h0002);
    check("t5_restart_we", 32'(we_w[0]), 32'd1);
    check("t5_restart_addr", 32'(addr_w[0]), 32'h100);

    // Test 3: DECIM=4 accepts every 4th pulse
    do_reset();
    send(16'hFFFB);
    check("t3_p1", 32'(we_w[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(16'h1234);
      check("t3_skip", 32'(we_w[1]), 32'd0);
    end
    send(16'h0003);
    check("t3_trig_we", 32'(we_w[1]), 32'd1);
    check("t3_trig_addr", 32'(addr_w[1]), 32'h100);
    for (int i = 0; i < 3; i++) begin
      send(16'h5555);
      check("t3_skip2", 32'(we_w[1]), 32'd0);
    end
    for (int v = 0; v < 8; v++) begin
      send(16'(v << 8));
      check("t3_we", 32'(we_w[1]), (v == 0 || v == 4) ? 32'd1 : 32'd0);
      if (v == 0) begin
        check("t3_addr0", 32'(addr_w[1]), 32'h101);
        check("t3_sample0", 32'(smp_w[1]), 32'h80);
      end
      if (v == 4) begin
        check("t3_addr4", 32'(addr_w[1]), 32'h102);
        check("t3_sample4", 32'(smp_w[1]), 32'h84);
      end
    end
    check("t3_index", 32'(dut_d.index_reg), 32'd3);

    // Test 4: TRIG_TIMEOUT=8 forced trigger and free_run
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      send(16'(k << 8));
      check("t4_no_trig", 32'(we_w[2]), 32'd0);
    end
    send(16'h0800);
    check("t4_trig_we", 32'(we_w[2]), 32'd1);
    check("t4_trig_addr", 32'(addr_w[2]), 32'h100);
    check("t4_trig_sample", 32'(smp_w[2]), 32'h88);
    check("t4_fr_before_flip", 32'(fr_w[2]), 32'd0);
    fill(2, 255, 9'h101);
    do_flip(2, 1'b1);
    check("t4_free_run", 32'(fr_w[2]), 32'd1);
    send(16'hFFFF);
    send(16'h0001);
    check("t4_cross_we", 32'(we_w[2]), 32'd1);
    check("t4_cross_addr", 32'(addr_w[2]), 32'h000);
    check("t4_free_run_held", 32'(fr_w[2]), 32'd1);

    // Test 6: crossing on the WAIT->ARMED cycle is ignored
    do_reset();
    send(16'hFFFF);
    send(16'h0001);
    check("t6_trig_addr", 32'(addr_w[0]), 32'h100);
    fill(0, 255, 9'h101);
    send(16'hFFFC);
    check("t6_wait_no_write", 32'(we_w[0]), 32'd0);
    @(negedge clk);
    wave_display_idle = 1'b1;
    new_sample_ready = 1'b1;
    new_sample_in = 16'h0005;
    @(negedge clk);
    wave_display_idle = 1'b0;
    new_sample_ready = 1'b0;
    check("t6_flip", 32'(flip_w[0]), 32'd1);
    check("t6_no_trig_we", 32'(we_w[0]), 32'd0);
    check("t6_state_armed", 32'(dut_a.state_reg), 32'(ARMED));
    @(negedge clk);
    check("t6_still_armed", 32'(dut_a.state_reg), 32'(ARMED));
    send(16'h0007);
    check("t6_pos_no_trig", 32'(we_w[0]), 32'd0);
    send(16'hFFFE);
    send(16'h0009);
    check("t6_retrig_we", 32'(we_w[0]), 32'd1);
    check("t6_retrig_addr", 32'(addr_w[0]), 32'h000);
    check("t6_retrig_sample", 32'(smp_w[0]), 32'h80);
    check("t6_state_active", 32'(dut_a.state_reg), 32'(ACTIVE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
